// File: rtl/io_sys_update_pkg.sv
// Shared definitions for the IO-mapped remote-update controller: FSM encoding,
// register offsets, one-hot access sizes and STAT/CTRL bit positions.
package io_sys_update_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdReq  = 3'd1,
        StWrReq  = 3'd2,
        StWait   = 3'd3,
        StDone   = 3'd4,
        StReconf = 3'd5
    } fsmState_t;

    localparam logic [15:0] OffCtrl = 16'h0000;
    localparam logic [15:0] OffAddr = 16'h0002;
    localparam logic [15:0] OffData = 16'h0004;
    localparam logic [15:0] OffKey  = 16'h0006;

    localparam logic [3:0] SzByte  = 4'b0001;
    localparam logic [3:0] SzWord  = 4'b0010;
    localparam logic [3:0] SzDword = 4'b0100;
    localparam logic [3:0] SzQword = 4'b1000;

    localparam int StatErrTmo = 5;
    localparam int StatErrKey = 4;
    localparam int StatArmed  = 3;

    localparam int CtrlReconf = 0;
    localparam int CtrlKick   = 1;
    localparam int CtrlClrErr = 2;

endpackage

// File: rtl/io_sys_update_kick.sv
// Watchdog kick generator. IO_SYS_UPDATE_AUTOKICK_EN selects a free-running
// square wave; otherwise each kick request stretches into a fixed-length pulse.
module io_sys_update_kick
    import io_sys_update_pkg::*;
#(
    parameter int CKickW = 8
) (
    input  logic AClkH,
    input  logic AResetH,
    input  logic AKick,
    output logic AResetTimer
);

    logic [CKickW-1:0] kickCntReg;

`ifdef IO_SYS_UPDATE_AUTOKICK_EN
    logic unusedKick;
    assign unusedKick = AKick;

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            kickCntReg <= '0;
        end else begin
            kickCntReg <= kickCntReg + 1'b1;
        end
    end

    assign AResetTimer = kickCntReg[CKickW-1];
`else
    localparam logic [CKickW-1:0] CPulseLen = {1'b1, {(CKickW-1){1'b0}}};

    // A retrigger reloads the full length rather than extending the remainder.
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            kickCntReg <= '0;
        end else if (AKick) begin
            kickCntReg <= CPulseLen;
        end else if (kickCntReg != '0) begin
            kickCntReg <= kickCntReg - 1'b1;
        end
    end

    assign AResetTimer = (kickCntReg != '0);
`endif

endmodule

// File: rtl/io_sys_update_ctrl.sv
// IO-mapped remote-update controller: param read/write handshake FSM, busy
// timeout, key-guarded reconfig; kick style chosen by IO_SYS_UPDATE_AUTOKICK_EN.
module io_sys_update_ctrl
    import io_sys_update_pkg::*;
#(
    parameter logic [15:0] CAddrBase  = 16'h0000,
    parameter int          CParamAW   = 3,
    parameter int          CDataW     = 32,
    parameter int          CTmoW      = 12,
    parameter int          CKickW     = 8,
    parameter logic [31:0] CReconfKey = 32'h5A5AC3C3
) (
    input  logic                AClkH,
    input  logic                AResetH,
    input  logic [15:0]         AIoAddr,
    input  logic [63:0]         AIoMosi,
    output logic [63:0]         AIoMiso,
    input  logic [3:0]          AIoWrSize,
    input  logic [3:0]          AIoRdSize,
    output logic                AIoAddrAck,
    output logic                AIoAddrErr,
    output logic                AIoBusy,
    output logic [CParamAW-1:0] ARuParam,
    output logic [1:0]          ARuSource,
    output logic [CDataW-1:0]   ARuDataO,
    input  logic [CDataW-1:0]   ARuDataI,
    output logic                ARuReadParam,
    output logic                ARuWriteParam,
    output logic                ARuReconfig,
    output logic                ARuResetTimer,
    input  logic                ARuBusy
);

    localparam logic [CTmoW-1:0] CTmoLast = {{(CTmoW-1){1'b1}}, 1'b0};

    fsmState_t           stateReg;
    logic [CParamAW+1:0] addrReg;
    logic [CDataW-1:0]   dataLatchReg;
    logic [CTmoW-1:0]    tmoCntReg;
    logic                opRdReg;
    logic                armedReg;
    logic                errTmoReg;
    logic                errKeyReg;

    logic hitCtrl, hitAddr, hitData, hitKey, hitAny;
    logic isWr, isRd, wrByte, rdByte, wrDword, rdDword;
    logic ctrlWr, statRd, addrWr, addrRd, dataWr, dataRd, keyWr;
    logic dataAcc, regAcc, legal, regsOpen, inFlight, kickReq;
    logic [5:0] stat;
    logic unusedMosi;

    assign unusedMosi = ^AIoMosi[63:32];

    assign hitCtrl = (AIoAddr == CAddrBase + OffCtrl);
    assign hitAddr = (AIoAddr == CAddrBase + OffAddr);
    assign hitData = (AIoAddr == CAddrBase + OffData);
    assign hitKey  = (AIoAddr == CAddrBase + OffKey);

    // A simultaneous read and write request is never a legal access.
    assign isWr    = |AIoWrSize;
    assign isRd    = |AIoRdSize;
    assign wrByte  = (AIoWrSize == SzByte)  && !isRd;
    assign rdByte  = (AIoRdSize == SzByte)  && !isWr;
    assign wrDword = (AIoWrSize == SzDword) && !isRd;
    assign rdDword = (AIoRdSize == SzDword) && !isWr;

    assign ctrlWr = hitCtrl && wrByte;
    assign statRd = hitCtrl && rdByte;
    assign addrWr = hitAddr && wrByte;
    assign addrRd = hitAddr && rdByte;
    assign dataWr = hitData && wrDword;
    assign dataRd = hitData && rdDword;
    assign keyWr  = hitKey  && wrDword;

    assign dataAcc = dataWr || dataRd;
    assign regAcc  = ctrlWr || statRd || addrWr || addrRd || keyWr;
    assign legal   = dataAcc || regAcc;
    assign hitAny  = (hitCtrl || hitAddr || hitData || hitKey) && (isWr || isRd);

    assign AIoAddrAck = legal;
    assign AIoAddrErr = hitAny && !legal;

    assign regsOpen = (stateReg != StReconf);
    assign inFlight = (stateReg == StRdReq) || (stateReg == StWrReq) || (stateReg == StWait);

    // Register accesses slip past an in-flight core transaction without stalling.
    assign AIoBusy = (stateReg == StReconf)
                  || ((stateReg == StIdle) && dataAcc)
                  || (inFlight && !regAcc);

    assign ARuParam  = addrReg[CParamAW-1:0];
    assign ARuSource = addrReg[CParamAW+1:CParamAW];

    always_comb begin
        stat             = '0;
        stat[2:0]        = stateReg;
        stat[StatArmed]  = armedReg;
        stat[StatErrKey] = errKeyReg;
        stat[StatErrTmo] = errTmoReg;
    end

    always_comb begin
        AIoMiso = '0;
        if (statRd) begin
            AIoMiso[5:0] = stat;
        end else if (addrRd) begin
            AIoMiso[CParamAW+1:0] = addrReg;
        end else if (dataRd) begin
            AIoMiso[CDataW-1:0] = dataLatchReg;
        end
    end

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            stateReg      <= StIdle;
            ARuReadParam  <= 1'b0;
            ARuWriteParam <= 1'b0;
            ARuReconfig   <= 1'b0;
            ARuDataO      <= '0;
            addrReg       <= '0;
            dataLatchReg  <= '0;
            tmoCntReg     <= '0;
            opRdReg       <= 1'b0;
            armedReg      <= 1'b0;
            errTmoReg     <= 1'b0;
            errKeyReg     <= 1'b0;
        end else begin
            ARuReadParam  <= 1'b0;
            ARuWriteParam <= 1'b0;

            // Placed first so any error set later in this block wins.
            if (regsOpen && ctrlWr && AIoMosi[CtrlClrErr]) begin
                errTmoReg <= 1'b0;
                errKeyReg <= 1'b0;
            end

            case (stateReg)
                StIdle: begin
                    if (dataRd) begin
                        stateReg     <= StRdReq;
                        ARuReadParam <= 1'b1;
                        opRdReg      <= 1'b1;
                    end else if (dataWr) begin
                        stateReg      <= StWrReq;
                        ARuWriteParam <= 1'b1;
                        opRdReg       <= 1'b0;
                        ARuDataO      <= AIoMosi[CDataW-1:0];
                    end else if (ctrlWr && AIoMosi[CtrlReconf] && armedReg) begin
                        stateReg    <= StReconf;
                        ARuReconfig <= 1'b1;
                    end
                end
                StRdReq, StWrReq: begin
                    stateReg  <= StWait;
                    tmoCntReg <= '0;
                end
                StWait: begin
                    if (!ARuBusy) begin
                        stateReg <= StDone;
                        if (opRdReg) begin
                            dataLatchReg <= ARuDataI;
                        end
                    end else if (tmoCntReg == CTmoLast) begin
                        stateReg     <= StDone;
                        errTmoReg    <= 1'b1;
                        dataLatchReg <= '0;
                    end else begin
                        tmoCntReg <= tmoCntReg + 1'b1;
                    end
                end
                StDone:   stateReg <= StIdle;
                StReconf: stateReg <= StReconf;
                default:  stateReg <= StIdle;
            endcase

            if (regsOpen) begin
                if (addrWr && stateReg == StIdle) begin
                    addrReg <= AIoMosi[CParamAW+1:0];
                end
                if (dataAcc) begin
                    armedReg <= 1'b0;
                end
                if (keyWr) begin
                    if (AIoMosi[31:0] == CReconfKey) begin
                        armedReg <= 1'b1;
                    end else begin
                        armedReg  <= 1'b0;
                        errKeyReg <= 1'b1;
                    end
                end
                if (ctrlWr && AIoMosi[CtrlReconf] && !(armedReg && stateReg == StIdle)) begin
                    errKeyReg <= 1'b1;
                end
            end
        end
    end

    assign kickReq = regsOpen && ctrlWr && AIoMosi[CtrlKick];

    io_sys_update_kick #(
        .CKickW(CKickW)
    ) uKick (
        .AClkH      (AClkH),
        .AResetH    (AResetH),
        .AKick      (kickReq),
        .AResetTimer(ARuResetTimer)
    );

endmodule

// File: tb/tb_io_sys_update_ctrl.sv
// Directed bench for io_sys_update_ctrl with CTmoW=4; kick checks follow
// IO_SYS_UPDATE_AUTOKICK_EN when it is defined.
module tb_io_sys_update_ctrl;

    logic        AClkH = 1'b0;
    logic        AResetH;
    logic [15:0] AIoAddr;
    logic [63:0] AIoMosi;
    logic [63:0] AIoMiso;
    logic [3:0]  AIoWrSize;
    logic [3:0]  AIoRdSize;
    logic        AIoAddrAck;
    logic        AIoAddrErr;
    logic        AIoBusy;
    logic [2:0]  ARuParam;
    logic [1:0]  ARuSource;
    logic [31:0] ARuDataO;
    logic [31:0] ARuDataI;
    logic        ARuReadParam;
    logic        ARuWriteParam;
    logic        ARuReconfig;
    logic        ARuResetTimer;
    logic        ARuBusy;

    int passCnt = 0;
    int totalCnt = 0;

    always #5 AClkH = ~AClkH;

    io_sys_update_ctrl #(
        .CAddrBase (16'h0000),
        .CParamAW  (3),
        .CDataW    (32),
        .CTmoW     (4),
        .CKickW    (8),
        .CReconfKey(32'h5A5AC3C3)
    ) dut (
        .AClkH        (AClkH),
        .AResetH      (AResetH),
        .AIoAddr      (AIoAddr),
        .AIoMosi      (AIoMosi),
        .AIoMiso      (AIoMiso),
        .AIoWrSize    (AIoWrSize),
        .AIoRdSize    (AIoRdSize),
        .AIoAddrAck   (AIoAddrAck),
        .AIoAddrErr   (AIoAddrErr),
        .AIoBusy      (AIoBusy),
        .ARuParam     (ARuParam),
        .ARuSource    (ARuSource),
        .ARuDataO     (ARuDataO),
        .ARuDataI     (ARuDataI),
        .ARuReadParam (ARuReadParam),
        .ARuWriteParam(ARuWriteParam),
        .ARuReconfig  (ARuReconfig),
        .ARuResetTimer(ARuResetTimer),
        .ARuBusy      (ARuBusy)
    );

    task automatic tick();
        @(posedge AClkH);
        #2;
    endtask

    task automatic ioClr();
        AIoAddr = 16'h0; AIoMosi = 64'h0; AIoWrSize = 4'h0; AIoRdSize = 4'h0;
    endtask

    task automatic ioSet(input logic [15:0] a, input logic [3:0] wr, input logic [3:0] rd, input logic [63:0] d);
        AIoAddr = a; AIoWrSize = wr; AIoRdSize = rd; AIoMosi = d;
        #1;
    endtask

    task automatic ioWr(input logic [15:0] a, input logic [3:0] wr, input logic [63:0] d);
        ioSet(a, wr, 4'h0, d);
        tick();
        ioClr();
    endtask

    task automatic readStat(output logic [63:0] v);
        ioSet(16'h0000, 4'h0, 4'b0001, 64'h0);
        v = AIoMiso;
        ioClr();
        tick();
    endtask

    task automatic doReset();
        AResetH = 1'b1;
        tick();
        tick();
        AResetH = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [63:0] v;
        totalCnt++;
        if ({ARuReadParam, ARuWriteParam, ARuReconfig, ARuResetTimer, AIoBusy} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000", {ARuReadParam, ARuWriteParam, ARuReconfig, ARuResetTimer, AIoBusy});
        else passCnt++;
        totalCnt++;
        if ({ARuSource, ARuParam, ARuDataO} !== 37'h0)
            $display("FAIL reset_regs: got src=%0h param=%0h datao=%h want 0", ARuSource, ARuParam, ARuDataO);
        else passCnt++;
        readStat(v);
        totalCnt++;
        if (v !== 64'h0) $display("FAIL reset_stat: got %h want 0", v); else passCnt++;
    endtask

    task automatic test_addr();
        ioWr(16'h0002, 4'b0001, 64'hFFFF_0000_0000_001D);
        totalCnt++;
        if (ARuSource !== 2'd3 || ARuParam !== 3'd5)
            $display("FAIL addr_write: got src=%0d param=%0d want src=3 param=5", ARuSource, ARuParam);
        else passCnt++;
        ioSet(16'h0002, 4'h0, 4'b0001, 64'h0);
        totalCnt++;
        if (AIoMiso !== 64'h1D || AIoAddrAck !== 1'b1 || AIoBusy !== 1'b0)
            $display("FAIL addr_read: got miso=%h ack=%b busy=%b want 1d/1/0", AIoMiso, AIoAddrAck, AIoBusy);
        else passCnt++;
        ioClr();
        tick();
    endtask

    task automatic test_data_read();
        ARuBusy = 1'b0;
        ARuDataI = 32'h0000_1234;
        ioSet(16'h0004, 4'h0, 4'b0100, 64'h0);
        totalCnt++;
        if (AIoBusy !== 1'b1 || AIoAddrAck !== 1'b1 || ARuReadParam !== 1'b0)
            $display("FAIL rd_cyc0: got busy=%b ack=%b strobe=%b want 1/1/0", AIoBusy, AIoAddrAck, ARuReadParam);
        else passCnt++;
        tick();
        totalCnt++;
        if (ARuReadParam !== 1'b1 || ARuWriteParam !== 1'b0 || AIoBusy !== 1'b1)
            $display("FAIL rd_cyc1_strobe: got rd=%b wr=%b busy=%b want 1/0/1", ARuReadParam, ARuWriteParam, AIoBusy);
        else passCnt++;
        tick();
        totalCnt++;
        if (ARuReadParam !== 1'b0 || AIoBusy !== 1'b1)
            $display("FAIL rd_cyc2_wait: got rd=%b busy=%b want 0/1", ARuReadParam, AIoBusy);
        else passCnt++;
        tick();
        totalCnt++;
        if (AIoBusy !== 1'b0 || AIoMiso !== 64'h1234)
            $display("FAIL rd_cyc3_done: got busy=%b miso=%h want 0/1234", AIoBusy, AIoMiso);
        else passCnt++;
        ioClr();
        tick();
    endtask

    task automatic test_data_write_busy();
        int strobes = 0;
        int badWait = 0;
        ARuBusy = 1'b1;
        ioSet(16'h0004, 4'b0100, 4'h0, 64'h1111_2222_DEAD_BEEF);
        tick();
        strobes += int'(ARuWriteParam);
        totalCnt++;
        if (ARuWriteParam !== 1'b1 || ARuDataO !== 32'hDEADBEEF)
            $display("FAIL wr_cyc1: got strobe=%b datao=%h want 1/deadbeef", ARuWriteParam, ARuDataO);
        else passCnt++;
        for (int i = 0; i < 10; i++) begin
            tick();
            strobes += int'(ARuWriteParam);
            if (AIoBusy !== 1'b1) badWait++;
        end
        tick();
        ARuBusy = 1'b0;
        #1;
        if (AIoBusy !== 1'b1) badWait++;
        totalCnt++;
        if (badWait != 0) $display("FAIL wr_wait_busy: got %0d low cycles want 0", badWait); else passCnt++;
        tick();
        totalCnt++;
        if (AIoBusy !== 1'b0 || strobes != 1 || ARuDataO !== 32'hDEADBEEF)
            $display("FAIL wr_done: got busy=%b strobes=%0d datao=%h want 0/1/deadbeef", AIoBusy, strobes, ARuDataO);
        else passCnt++;
        ioClr();
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        logic [63:0] v;
        ARuBusy = 1'b1;
        ARuDataI = 32'h5555_5555;
        ioSet(16'h0004, 4'h0, 4'b0100, 64'h0);
        while (AIoBusy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        totalCnt++;
        if (n != 17 || AIoMiso !== 64'h0)
            $display("FAIL tmo_done: got cycles=%0d miso=%h want 17/0", n, AIoMiso);
        else passCnt++;
        ioClr();
        ARuBusy = 1'b0;
        tick();
        readStat(v);
        totalCnt++;
        if (v !== 64'h20) $display("FAIL tmo_stat: got %h want 20", v); else passCnt++;
        ioWr(16'h0000, 4'b0001, 64'h4);
        readStat(v);
        totalCnt++;
        if (v !== 64'h0) $display("FAIL tmo_clear: got %h want 0", v); else passCnt++;
    endtask

    task automatic test_key_bad();
        logic [63:0] v;
        ioWr(16'h0006, 4'b0100, 64'h0);
        ioSet(16'h0000, 4'b0001, 4'h0, 64'h1);
        totalCnt++;
        if (AIoBusy !== 1'b0 || AIoAddrAck !== 1'b1)
            $display("FAIL keybad_ctrl_nostall: got busy=%b ack=%b want 0/1", AIoBusy, AIoAddrAck);
        else passCnt++;
        tick();
        ioClr();
        tick();
        readStat(v);
        totalCnt++;
        if (v !== 64'h10 || ARuReconfig !== 1'b0)
            $display("FAIL keybad_stat: got stat=%h reconf=%b want 10/0", v, ARuReconfig);
        else passCnt++;
        // reconfig request and clear in the same write: the set must win
        ioWr(16'h0000, 4'b0001, 64'h5);
        readStat(v);
        totalCnt++;
        if (v !== 64'h10) $display("FAIL keybad_setwins: got %h want 10", v); else passCnt++;
        ioWr(16'h0000, 4'b0001, 64'h4);
        readStat(v);
        totalCnt++;
        if (v !== 64'h0) $display("FAIL keybad_clear: got %h want 0", v); else passCnt++;
    endtask

    task automatic test_illegal();
        int strobes = 0;
        logic [63:0] v;
        ioSet(16'h0004, 4'b0010, 4'h0, 64'hFFFF);
        totalCnt++;
        if (AIoAddrErr !== 1'b1 || AIoAddrAck !== 1'b0 || AIoBusy !== 1'b0)
            $display("FAIL illegal_word_data: got err=%b ack=%b busy=%b want 1/0/0", AIoAddrErr, AIoAddrAck, AIoBusy);
        else passCnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            strobes += int'(ARuReadParam) + int'(ARuWriteParam);
        end
        ioClr();
        totalCnt++;
        if (strobes != 0) $display("FAIL illegal_nostrobe: got %0d strobes want 0", strobes); else passCnt++;
        ioSet(16'h0006, 4'h0, 4'b0100, 64'h0);
        totalCnt++;
        if (AIoAddrErr !== 1'b1 || AIoMiso !== 64'h0)
            $display("FAIL illegal_key_read: got err=%b miso=%h want 1/0", AIoAddrErr, AIoMiso);
        else passCnt++;
        ioSet(16'h0010, 4'h0, 4'b0001, 64'h0);
        totalCnt++;
        if (AIoAddrErr !== 1'b0 || AIoAddrAck !== 1'b0 || AIoMiso !== 64'h0)
            $display("FAIL unaddressed: got err=%b ack=%b miso=%h want 0/0/0", AIoAddrErr, AIoAddrAck, AIoMiso);
        else passCnt++;
        ioClr();
        tick();
        readStat(v);
        totalCnt++;
        if (v !== 64'h0) $display("FAIL illegal_stat: got %h want 0", v); else passCnt++;
    endtask

    task automatic test_kick();
        int n = 0;
`ifdef IO_SYS_UPDATE_AUTOKICK_EN
        while (ARuResetTimer !== 1'b0 && n < 300) begin tick(); n++; end
        n = 0;
        while (ARuResetTimer !== 1'b1 && n < 300) begin tick(); n++; end
        n = 0;
        while (ARuResetTimer === 1'b1 && n < 300) begin tick(); n++; end
        totalCnt++;
        if (n != 128) $display("FAIL autokick_high: got %0d want 128", n); else passCnt++;
        n = 0;
        while (ARuResetTimer === 1'b0 && n < 300) begin tick(); n++; end
        totalCnt++;
        if (n != 128) $display("FAIL autokick_low: got %0d want 128", n); else passCnt++;
`else
        totalCnt++;
        if (ARuResetTimer !== 1'b0) $display("FAIL kick_idle: got %b want 0", ARuResetTimer); else passCnt++;
        ioWr(16'h0000, 4'b0001, 64'h2);
        while (ARuResetTimer === 1'b1 && n < 300) begin n++; tick(); end
        totalCnt++;
        if (n != 128) $display("FAIL kick_pulse: got %0d cycles want 128", n); else passCnt++;
        ioWr(16'h0000, 4'b0001, 64'h2);
        repeat (10) tick();
        ioWr(16'h0000, 4'b0001, 64'h2);
        n = 0;
        while (ARuResetTimer === 1'b1 && n < 300) begin n++; tick(); end
        totalCnt++;
        if (n != 128) $display("FAIL kick_retrigger: got %0d cycles want 128", n); else passCnt++;
`endif
    endtask

    task automatic test_reset_mid();
        logic [63:0] v;
        ARuBusy = 1'b1;
        ioSet(16'h0004, 4'h0, 4'b0100, 64'h0);
        tick();
        tick();
        AResetH = 1'b1;
        tick();
        ioClr();
        #1;
        totalCnt++;
        if (ARuReadParam !== 1'b0 || ARuWriteParam !== 1'b0 || AIoBusy !== 1'b0)
            $display("FAIL resetmid_strobes: got rd=%b wr=%b busy=%b want 0/0/0", ARuReadParam, ARuWriteParam, AIoBusy);
        else passCnt++;
        AResetH = 1'b0;
        ARuBusy = 1'b0;
        tick();
        readStat(v);
        totalCnt++;
        if (v !== 64'h0 || ARuReadParam !== 1'b0)
            $display("FAIL resetmid_idle: got stat=%h rd=%b want 0/0", v, ARuReadParam);
        else passCnt++;
    endtask

    task automatic test_reconf();
        int strobes = 0;
        logic [63:0] v;
        ioWr(16'h0006, 4'b0100, 64'h5A5A_C3C3);
        readStat(v);
        totalCnt++;
        if (v !== 64'h08) $display("FAIL reconf_armed: got %h want 08", v); else passCnt++;
        ioWr(16'h0000, 4'b0001, 64'h1);
        totalCnt++;
        if (ARuReconfig !== 1'b1 || AIoBusy !== 1'b1)
            $display("FAIL reconf_enter: got reconf=%b busy=%b want 1/1", ARuReconfig, AIoBusy);
        else passCnt++;
        ioSet(16'h0004, 4'h0, 4'b0100, 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            strobes += int'(ARuReadParam) + int'(ARuWriteParam);
        end
        totalCnt++;
        if (strobes != 0 || AIoBusy !== 1'b1 || ARuReconfig !== 1'b1)
            $display("FAIL reconf_hold: got strobes=%0d busy=%b reconf=%b want 0/1/1", strobes, AIoBusy, ARuReconfig);
        else passCnt++;
        ioClr();
        AResetH = 1'b1;
        tick();
        AResetH = 1'b0;
        #1;
        totalCnt++;
        if (ARuReconfig !== 1'b0 || AIoBusy !== 1'b0)
            $display("FAIL reconf_reset: got reconf=%b busy=%b want 0/0", ARuReconfig, AIoBusy);
        else passCnt++;
    endtask

    initial begin
        ioClr();
        ARuBusy = 1'b0;
        ARuDataI = 32'h0;
        AResetH = 1'b1;
        doReset();
        test_reset();
        test_addr();
        test_data_read();
        test_data_write_busy();
        test_timeout();
        test_key_bad();
        test_illegal();
        test_kick();
        test_reset_mid();
        test_reconf();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
